// File: rtl/mpc_memctl_req_if.sv
// Request/command/response bundle for the MPC memory-controller front-end.
// slave = the front-end itself, master = the surrounding environment.
interface mpc_memctl_req_if #(
    parameter int unsigned NLINE_W = 8,
    parameter int unsigned ADDR_W  = 32
) ();
    logic               u_awvalid;
    logic               u_awready;
    logic [NLINE_W-1:0] u_awid;
    logic [ADDR_W-1:0]  u_awaddr;
    logic               u_arvalid;
    logic               u_arready;
    logic [NLINE_W-1:0] u_arid;
    logic [ADDR_W-1:0]  u_araddr;
    logic               m_cmd_valid;
    logic               m_cmd_ready;
    logic               m_cmd_write;
    logic [NLINE_W-1:0] m_cmd_id;
    logic [ADDR_W-1:0]  m_cmd_addr;
    logic               m_rsp_valid;
    logic               m_rsp_write;
    logic [NLINE_W-1:0] m_rsp_id;
    logic               d_refill_done_valid;
    logic [NLINE_W-1:0] d_refill_done_id;
    logic               err;

    modport slave (
        input  u_awvalid, u_awid, u_awaddr,
        input  u_arvalid, u_arid, u_araddr,
        input  m_cmd_ready, m_rsp_valid, m_rsp_write, m_rsp_id,
        output u_awready, u_arready,
        output m_cmd_valid, m_cmd_write, m_cmd_id, m_cmd_addr,
        output d_refill_done_valid, d_refill_done_id, err
    );

    modport master (
        output u_awvalid, u_awid, u_awaddr,
        output u_arvalid, u_arid, u_araddr,
        output m_cmd_ready, m_rsp_valid, m_rsp_write, m_rsp_id,
        input  u_awready, u_arready,
        input  m_cmd_valid, m_cmd_write, m_cmd_id, m_cmd_addr,
        input  d_refill_done_valid, d_refill_done_id, err
    );
endinterface

// File: rtl/mpc_memctl_req.sv
// MPC memory-controller request front-end: buffers write-back (AW) and
// line-fill (AR) requests, holds a line-fill behind any write-back to the
// same nline id, and issues line-aligned commands under an outstanding limit.
// Build option: define MPC_MEMCTL_WR_PRIO_EN for strict write priority;
// otherwise AW/AR are arbitrated round-robin.
module mpc_memctl_req #(
    parameter int unsigned NLINE_W    = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_OFS_W = 6,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_OUT    = 8
) (
    input  logic            clk,
    input  logic            rst,
    mpc_memctl_req_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = 1;
    localparam logic [PTR_W:0]    QCNT_ONE  = 1;
    localparam logic [PTR_W:0]    QCNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
    localparam logic [CNT_W:0]    CNT_LIMIT = (CNT_W+1)'(MAX_OUT);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFS_W;

    // AW queue
    logic [NLINE_W-1:0] aw_id_q   [DEPTH];
    logic [ADDR_W-1:0]  aw_addr_q [DEPTH];
    logic [DEPTH-1:0]   aw_vld;
    logic [PTR_W-1:0]   aw_wp, aw_rp;
    logic [PTR_W:0]     aw_cnt;
    logic               aw_push, aw_pop;

    // AR queue
    logic [NLINE_W-1:0] ar_id_q   [DEPTH];
    logic [ADDR_W-1:0]  ar_addr_q [DEPTH];
    logic [PTR_W-1:0]   ar_wp, ar_rp;
    logic [PTR_W:0]     ar_cnt;
    logic               ar_push, ar_pop;

    // Command register and bookkeeping
    logic               cmd_valid, cmd_write;
    logic [NLINE_W-1:0] cmd_id;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W:0]     committed;
    logic               fire, load, sel_write;
    logic               aw_elig, ar_elig, ar_hazard;
    logic [NLINE_W-1:0] ar_head_id;

    assign bus.u_awready = (aw_cnt != QCNT_FULL);
    assign bus.u_arready = (ar_cnt != QCNT_FULL);
    assign aw_push = bus.u_awvalid & bus.u_awready;
    assign ar_push = bus.u_arvalid & bus.u_arready;
    assign aw_pop  = load & sel_write;
    assign ar_pop  = load & ~sel_write;
    assign fire    = cmd_valid & bus.m_cmd_ready;

    assign ar_head_id = ar_id_q[ar_rp];
    assign aw_elig    = (aw_cnt != '0);
    assign ar_elig    = (ar_cnt != '0) && !ar_hazard;

    // The command sitting in the register counts against the limit until it
    // hands off into out_cnt, so a new load needs room for one more on top.
    assign committed = {1'b0, out_cnt} + {{CNT_W{1'b0}}, cmd_valid};
    assign load = (!cmd_valid || bus.m_cmd_ready) && (committed < CNT_LIMIT)
                  && (aw_elig || ar_elig);

    // Line-fill hazard: AR head id collides with any queued or held write-back
    always_comb begin
        ar_hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (aw_vld[i] && (aw_id_q[i] == ar_head_id)) ar_hazard = 1'b1;
        end
        if (cmd_valid && cmd_write && (cmd_id == ar_head_id)) ar_hazard = 1'b1;
    end

`ifdef MPC_MEMCTL_WR_PRIO_EN
    assign sel_write = aw_elig;
`else
    typedef enum logic {GRANT_WR, GRANT_RD} grant_e;
    grant_e last_grant;

    assign sel_write = aw_elig && (!ar_elig || (last_grant == GRANT_RD));

    // Round-robin pointer: remembers which stream won the last load
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_grant <= GRANT_RD;
        else if (load) last_grant <= sel_write ? GRANT_WR : GRANT_RD;
    end
`endif

    // AW queue pointers, occupancy and per-slot valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wp <= '0; aw_rp <= '0; aw_cnt <= '0; aw_vld <= '0;
        end else begin
            if (aw_pop) begin
                aw_rp         <= aw_rp + PTR_ONE;
                aw_vld[aw_rp] <= 1'b0;
            end
            if (aw_push) begin
                aw_wp         <= aw_wp + PTR_ONE;
                aw_vld[aw_wp] <= 1'b1;
            end
            if (aw_push && !aw_pop)      aw_cnt <= aw_cnt + QCNT_ONE;
            else if (!aw_push && aw_pop) aw_cnt <= aw_cnt - QCNT_ONE;
        end
    end

    // AR queue pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_wp <= '0; ar_rp <= '0; ar_cnt <= '0;
        end else begin
            if (ar_pop)  ar_rp <= ar_rp + PTR_ONE;
            if (ar_push) ar_wp <= ar_wp + PTR_ONE;
            if (ar_push && !ar_pop)      ar_cnt <= ar_cnt + QCNT_ONE;
            else if (!ar_push && ar_pop) ar_cnt <= ar_cnt - QCNT_ONE;
        end
    end

    // Queue payload storage (no reset needed, guarded by valid/occupancy)
    always_ff @(posedge clk) begin
        if (aw_push) begin
            aw_id_q[aw_wp]   <= bus.u_awid;
            aw_addr_q[aw_wp] <= bus.u_awaddr;
        end
        if (ar_push) begin
            ar_id_q[ar_wp]   <= bus.u_arid;
            ar_addr_q[ar_wp] <= bus.u_araddr;
        end
    end

    // One-entry command register; held stable while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0; cmd_write <= 1'b0; cmd_id <= '0; cmd_addr <= '0;
        end else if (load) begin
            cmd_valid <= 1'b1;
            cmd_write <= sel_write;
            cmd_id    <= sel_write ? aw_id_q[aw_rp] : ar_head_id;
            cmd_addr  <= (sel_write ? aw_addr_q[aw_rp] : ar_addr_q[ar_rp]) & LINE_MASK;
        end else if (fire) begin
            cmd_valid <= 1'b0;
        end
    end

    // Outstanding counter, sticky error and refill completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0; bus.err <= 1'b0;
            bus.d_refill_done_valid <= 1'b0; bus.d_refill_done_id <= '0;
        end else begin
            if (fire && !bus.m_rsp_valid) begin
                out_cnt <= out_cnt + CNT_ONE;
            end else if (!fire && bus.m_rsp_valid) begin
                if (out_cnt == '0) bus.err <= 1'b1;
                else               out_cnt <= out_cnt - CNT_ONE;
            end
            bus.d_refill_done_valid <= bus.m_rsp_valid & ~bus.m_rsp_write;
            if (bus.m_rsp_valid && !bus.m_rsp_write) bus.d_refill_done_id <= bus.m_rsp_id;
        end
    end

    assign bus.m_cmd_valid = cmd_valid;
    assign bus.m_cmd_write = cmd_write;
    assign bus.m_cmd_id    = cmd_id;
    assign bus.m_cmd_addr  = cmd_addr;
endmodule

// File: tb/tb_mpc_memctl_req.sv
// Directed bench for mpc_memctl_req with a command scoreboard.
module tb_mpc_memctl_req;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   hs_cnt = 0;
    logic [63:0] cmd_q [$];

    mpc_memctl_req_if #(.NLINE_W(8), .ADDR_W(32)) bus ();

    mpc_memctl_req #(
        .NLINE_W(8), .ADDR_W(32), .LINE_OFS_W(6), .DEPTH(4), .MAX_OUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic w, input logic [7:0] id, input logic [31:0] a);
        return {23'd0, w, id, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command scoreboard: every handshake must match the next expectation
    always @(negedge clk) begin
        if (!rst && bus.m_cmd_valid === 1'b1 && bus.m_cmd_ready === 1'b1) begin
            logic [63:0] exp;
            hs_cnt++;
            exp = (cmd_q.size() != 0) ? cmd_q.pop_front() : '1;
            check("cmd", pack(bus.m_cmd_write, bus.m_cmd_id, bus.m_cmd_addr), exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] a);
        int n = 0;
        bus.u_awvalid = 1'b1; bus.u_awid = id; bus.u_awaddr = a;
        while (bus.u_awready !== 1'b1 && n < 50) begin step(); n++; end
        check("aw_accept", bus.u_awready, 1);
        step();
        bus.u_awvalid = 1'b0;
        cmd_q.push_back(pack(1'b1, id, a & 32'hFFFF_FFC0));
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] a);
        int n = 0;
        bus.u_arvalid = 1'b1; bus.u_arid = id; bus.u_araddr = a;
        while (bus.u_arready !== 1'b1 && n < 50) begin step(); n++; end
        check("ar_accept", bus.u_arready, 1);
        step();
        bus.u_arvalid = 1'b0;
        cmd_q.push_back(pack(1'b0, id, a & 32'hFFFF_FFC0));
    endtask

    task automatic rsp(input logic w, input logic [7:0] id);
        bus.m_rsp_valid = 1'b1; bus.m_rsp_write = w; bus.m_rsp_id = id;
        step();
        bus.m_rsp_valid = 1'b0;
        check("refill_valid", bus.d_refill_done_valid, !w);
        if (!w) check("refill_id", bus.d_refill_done_id, id);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && cmd_q.size() != 0; n++) step();
        check(tag, cmd_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_awready"}, bus.u_awready, 1);
        check({tag, "_arready"}, bus.u_arready, 1);
        check({tag, "_cmd_valid"}, bus.m_cmd_valid, 0);
        check({tag, "_cmd_write"}, bus.m_cmd_write, 0);
        check({tag, "_cmd_id"}, bus.m_cmd_id, 0);
        check({tag, "_cmd_addr"}, bus.m_cmd_addr, 0);
        check({tag, "_refill_valid"}, bus.d_refill_done_valid, 0);
        check({tag, "_refill_id"}, bus.d_refill_done_id, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_out_cnt"}, dut.out_cnt, 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.u_awvalid = 0; bus.u_awid = 0; bus.u_awaddr = 0;
        bus.u_arvalid = 0; bus.u_arid = 0; bus.u_araddr = 0;
        bus.m_cmd_ready = 0; bus.m_rsp_valid = 0; bus.m_rsp_write = 0; bus.m_rsp_id = 0;
        step(); step();
        check_reset_values("rst");
        rst = 1'b0;
        step();

        // Dirty miss: write-back and line-fill to the same nline id together
        bus.m_cmd_ready = 1'b1;
        bus.u_awvalid = 1; bus.u_awid = 8'h12; bus.u_awaddr = 32'h1000_0047;
        bus.u_arvalid = 1; bus.u_arid = 8'h12; bus.u_araddr = 32'h2000_0040;
        check("dm_awready", bus.u_awready, 1);
        check("dm_arready", bus.u_arready, 1);
        cmd_q.push_back(pack(1'b1, 8'h12, 32'h1000_0040));
        cmd_q.push_back(pack(1'b0, 8'h12, 32'h2000_0040));
        step();
        bus.u_awvalid = 0; bus.u_arvalid = 0;
        check("dm_lat_t1", bus.m_cmd_valid, 0);
        step();
        check("dm_lat_t2", bus.m_cmd_valid, 1);
        drain("dm_drain");
        rsp(1'b1, 8'h12);
        rsp(1'b0, 8'h12);
        step();
        check("dm_pulse_end", bus.d_refill_done_valid, 0);

        // Hazard: AR 5 and AR 6 wait behind a stalled write-back to id 5
        bus.m_cmd_ready = 1'b0;
        send_aw(8'h05, 32'h0000_0513);
        send_ar(8'h05, 32'h0000_5000);
        send_ar(8'h06, 32'h0000_6000);
        for (int i = 0; i < 8; i++) begin
            check("hz_hold_write", bus.m_cmd_write, 1);
            check("hz_hold_id", bus.m_cmd_id, 5);
            step();
        end
        bus.m_cmd_ready = 1'b1;
        drain("hz_drain");
        rsp(1'b1, 8'h05);
        rsp(1'b0, 8'h05);
        rsp(1'b0, 8'h06);

        // Outstanding limit with no responses
        check("lim_start_cnt", dut.out_cnt, 0);
        base = hs_cnt;
        for (int i = 0; i < 10; i++) send_ar(8'h20 + 8'(i), 32'h4000_0000 + 32'(i * 64) + 32'h11);
        for (int i = 0; i < 15; i++) step();
        check("lim_hs8", hs_cnt - base, 8);
        check("lim_valid_low", bus.m_cmd_valid, 0);
        check("lim_cnt8", dut.out_cnt, 8);
        rsp(1'b0, 8'h20);
        for (int i = 0; i < 10; i++) step();
        check("lim_hs9", hs_cnt - base, 9);
        rsp(1'b0, 8'h21);
        drain("lim_drain");
        for (int i = 2; i < 10; i++) rsp(1'b0, 8'h20 + 8'(i));
        check("lim_end_cnt", dut.out_cnt, 0);

        // Full AW queue (command register already holding one write)
        bus.m_cmd_ready = 1'b0;
        send_aw(8'h3F, 32'h3000_0FFF);
        step(); step();
        for (int i = 0; i < 4; i++) send_aw(8'h40 + 8'(i), 32'h3000_1000 + 32'(i * 64) + 32'h3F);
        check("full_awready", bus.u_awready, 0);
        bus.u_awvalid = 1; bus.u_awid = 8'h44; bus.u_awaddr = 32'h3000_2000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_hold", bus.u_awready, 0);
        end
        bus.u_awvalid = 0;
        bus.m_cmd_ready = 1'b1;
        drain("full_drain");
        for (int i = 0; i < 4; i++) step();
        check("full_no_extra", bus.m_cmd_valid, 0);
        rsp(1'b1, 8'h3F);
        for (int i = 0; i < 4; i++) rsp(1'b1, 8'h40 + 8'(i));

        // Arbitration with both queues backlogged
        rst = 1'b1; step(); rst = 1'b0; step();
        bus.m_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.u_awvalid = 1; bus.u_awid = 8'h50 + 8'(i); bus.u_awaddr = 32'h5000_0000 + 32'(i * 64);
            bus.u_arvalid = 1; bus.u_arid = 8'h60 + 8'(i); bus.u_araddr = 32'h6000_0000 + 32'(i * 64);
            step();
        end
        bus.u_awvalid = 0; bus.u_arvalid = 0;
`ifdef MPC_MEMCTL_WR_PRIO_EN
        for (int i = 0; i < 3; i++) cmd_q.push_back(pack(1'b1, 8'h50 + 8'(i), 32'h5000_0000 + 32'(i * 64)));
        for (int i = 0; i < 3; i++) cmd_q.push_back(pack(1'b0, 8'h60 + 8'(i), 32'h6000_0000 + 32'(i * 64)));
`else
        for (int i = 0; i < 3; i++) begin
            cmd_q.push_back(pack(1'b1, 8'h50 + 8'(i), 32'h5000_0000 + 32'(i * 64)));
            cmd_q.push_back(pack(1'b0, 8'h60 + 8'(i), 32'h6000_0000 + 32'(i * 64)));
        end
`endif
        step();
        bus.m_cmd_ready = 1'b1;
        drain("arb_drain");

        // Response with nothing outstanding (reset drops the 6 in flight)
        rst = 1'b1; step(); rst = 1'b0; step();
        rsp(1'b0, 8'h77);
        check("err_set", bus.err, 1);
        check("err_cnt0", dut.out_cnt, 0);

        // Reset in the middle of a burst
        send_ar(8'h70, 32'h7000_0000);
        send_ar(8'h71, 32'h7000_0040);
        send_ar(8'h72, 32'h7000_0080);
        check("mid_valid", bus.m_cmd_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_values("mid");
        cmd_q.delete();
        step();
        rst = 1'b0;
        step();
        rsp(1'b0, 8'h71);
        check("late_err", bus.err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
